// File: rtl/rs_pkg.sv
// Shared GF(2^8) types, constants and helper functions for the Reed-Solomon syndrome datapath.
package rs_pkg;

    localparam int         GF_W         = 8;
    localparam logic [8:0] GF_PRIM_POLY = 9'h11D;

    // One syndrome / field symbol; syndrome arrays are unpacked arrays of gf_t.
    typedef logic [GF_W-1:0] gf_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rs_state_t;

    // Multiply by alpha (x) and reduce modulo the field polynomial.
    function automatic gf_t gf_xtime(input gf_t a, input logic [8:0] poly);
        return {a[6:0], 1'b0} ^ (a[7] ? poly[7:0] : 8'h00);
    endfunction

    function automatic gf_t gf_mul(input gf_t a, input gf_t b,
                                   input logic [8:0] poly = GF_PRIM_POLY);
        gf_t p;
        gf_t t;
        p = '0;
        t = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) p = p ^ t;
            t = gf_xtime(t, poly);
        end
        return p;
    endfunction

    // alpha^e; the multiplicative group has order 255, so e is reduced first.
    function automatic gf_t gf_alpha_pow(input int e, input logic [8:0] poly = GF_PRIM_POLY);
        gf_t r;
        int  em;
        r  = 8'h01;
        em = e % 255;
        for (int i = 0; i < 255; i++) begin
            if (i < em) r = gf_xtime(r, poly);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf256_mul_const.sv
// Combinational GF(2^8) multiply by an elaboration-time constant C.
module gf256_mul_const
    import rs_pkg::*;
#(
    parameter logic [7:0] C         = 8'h01,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic [7:0] a,
    output logic [7:0] y
);

    gf_t term;

    // term walks C*alpha^i; with C constant this folds to a fixed XOR network.
    always_comb begin
        y    = '0;
        term = C;
        for (int i = 0; i < GF_W; i++) begin
            if (a[i]) y = y ^ term;
            term = gf_xtime(term, PRIM_POLY);
        end
    end

endmodule

// File: rtl/rs_syndrome_param.sv
// Reed-Solomon syndrome calculator: Horner accumulation of N-K syndromes over a
// shortened codeword, results delivered through a one-entry valid/ready buffer.
module rs_syndrome_param
    import rs_pkg::*;
#(
    parameter int         N         = 16,
    parameter int         K         = 8,
    parameter int         FCR       = 1,
    parameter logic [8:0] PRIM_POLY = 9'h11D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_val,
    input  logic                  din_sop,
    input  logic                  din_eop,
    input  logic [7:0]            din,
    output logic                  din_rdy,
    output logic                  syn_val,
    input  logic                  syn_rdy,
    output logic [8*(N-K)-1:0]    syndrome,
    output logic                  syn_zero,
    output logic                  len_err
);

    localparam int NROOTS = N - K;
    localparam int CNT_W  = $clog2(256);

    rs_state_t        state;
    gf_t              s_q   [NROOTS];
    gf_t              s_mul [NROOTS];
    gf_t              s_nxt [NROOTS];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             acc;
    logic             take;
    logic             frame_done;
    logic             nxt_zero;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Input side stalls only while a held result is not being drained.
    assign din_rdy    = !(syn_val && !syn_rdy);
    assign acc        = din_val && din_rdy;
    assign take       = acc && (din_sop || state == ST_RUN);
    assign frame_done = take && din_eop;

    for (genvar j = 0; j < NROOTS; j++) begin : g_root
        gf256_mul_const #(
            .C         (gf_alpha_pow(FCR + j, PRIM_POLY)),
            .PRIM_POLY (PRIM_POLY)
        ) u_mul (
            .a (s_q[j]),
            .y (s_mul[j])
        );
    end

    // A sop restarts every accumulator, even mid-frame, discarding the old frame.
    always_comb begin
        cnt_nxt  = cnt_q;
        nxt_zero = 1'b1;
        for (int j = 0; j < NROOTS; j++) s_nxt[j] = s_q[j];
        if (acc && din_sop) begin
            for (int j = 0; j < NROOTS; j++) s_nxt[j] = din;
            cnt_nxt = CNT_W'(1);
        end else if (take) begin
            for (int j = 0; j < NROOTS; j++) s_nxt[j] = s_mul[j] ^ din;
            cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
        for (int j = 0; j < NROOTS; j++) begin
            if (s_nxt[j] != '0) nxt_zero = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt_q <= '0;
            for (int j = 0; j < NROOTS; j++) s_q[j] <= '0;
        end else begin
            if (take) begin
                for (int j = 0; j < NROOTS; j++) s_q[j] <= s_nxt[j];
                cnt_q <= cnt_nxt;
            end
            if (frame_done) begin
                state <= ST_IDLE;
            end else if (acc && din_sop) begin
                state <= ST_RUN;
            end
        end
    end

    // A new result may land in the same cycle the old one is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn_val  <= 1'b0;
            syndrome <= '0;
            syn_zero <= 1'b0;
            len_err  <= 1'b0;
        end else if (frame_done) begin
            syn_val  <= 1'b1;
            for (int j = 0; j < NROOTS; j++) syndrome[8*j +: 8] <= s_nxt[j];
            syn_zero <= nxt_zero;
            len_err  <= (int'(cnt_nxt) != N);
        end else if (syn_rdy) begin
            syn_val  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_syndrome_param.sv
// Self-checking bench for rs_syndrome_param: table vectors, corner sequences and
// randomized frames scored against a direct polynomial-evaluation model.
module tb_rs_syndrome_param;

    localparam int         N    = 16;
    localparam int         K    = 8;
    localparam int         FCR  = 1;
    localparam int         NR   = N - K;
    localparam int         SW   = 8 * NR;
    localparam int         MAXL = 300;
    localparam logic [8:0] POLY = 9'h11D;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          din_val = 1'b0;
    logic          din_sop = 1'b0;
    logic          din_eop = 1'b0;
    logic [7:0]    din     = 8'h00;
    logic          syn_rdy = 1'b1;
    logic          din_rdy;
    logic          syn_val;
    logic [SW-1:0] syndrome;
    logic          syn_zero;
    logic          len_err;

    rs_syndrome_param #(
        .N(N), .K(K), .FCR(FCR), .PRIM_POLY(POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din_val(din_val), .din_sop(din_sop),
        .din_eop(din_eop), .din(din), .din_rdy(din_rdy), .syn_val(syn_val),
        .syn_rdy(syn_rdy), .syndrome(syndrome), .syn_zero(syn_zero), .len_err(len_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_out = 0;
    logic rand_rdy_en = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy_en) syn_rdy = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected run completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(POLY) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] b, input int e);
        logic [7:0] r;
        r = 8'h01;
        repeat (e) r = gmul(r, b);
        return r;
    endfunction

    logic [7:0] frm [MAXL];
    int         frm_len;

    // S_j = r(alpha^(FCR+j)), r(x) = sum frm[i] * x^(L-1-i)
    function automatic logic [SW-1:0] model_syn();
        logic [SW-1:0] s;
        logic [7:0]    root;
        logic [7:0]    v;
        s = '0;
        for (int j = 0; j < NR; j++) begin
            root = gpow(8'h02, FCR + j);
            v    = 8'h00;
            for (int i = 0; i < frm_len; i++) v = v ^ gmul(frm[i], gpow(root, frm_len - 1 - i));
            s[8*j +: 8] = v;
        end
        return s;
    endfunction

    function automatic logic model_lerr();
        return ((frm_len > 255 ? 255 : frm_len) != N);
    endfunction

    task automatic fill_random(input int len);
        frm_len = len;
        for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
    endtask

    // Systematic encode of frm[0..K-1]: parity = m(x)*x^NR mod g(x).
    task automatic build_codeword();
        logic [7:0] g   [NR+1];
        logic [7:0] rem [NR];
        logic [7:0] r;
        logic [7:0] fb;
        for (int i = 0; i <= NR; i++) g[i] = 8'h00;
        g[0] = 8'h01;
        for (int j = 0; j < NR; j++) begin
            r = gpow(8'h02, FCR + j);
            for (int i = NR; i >= 1; i--) g[i] = g[i-1] ^ gmul(g[i], r);
            g[0] = gmul(g[0], r);
        end
        for (int i = 0; i < NR; i++) rem[i] = 8'h00;
        for (int m = 0; m < K; m++) begin
            fb = frm[m] ^ rem[NR-1];
            for (int i = NR - 1; i >= 1; i--) rem[i] = rem[i-1] ^ gmul(fb, g[i]);
            rem[0] = gmul(fb, g[0]);
        end
        for (int t = 0; t < NR; t++) frm[K+t] = rem[NR-1-t];
        frm_len = N;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [SW-1:0] syn;
        logic          zero;
        logic          lerr;
        logic          has_s0;
        logic [7:0]    s0;
    } exp_t;

    logic [$bits(exp_t)-1:0] exp_q[$];
    exp_t e;

    task automatic push_exp(input bit tbl, input logic [7:0] t_s0, input logic t_zero, input logic t_lerr);
        exp_t ne;
        ne.syn    = model_syn();
        ne.zero   = (ne.syn == '0);
        ne.lerr   = model_lerr();
        ne.has_s0 = 1'b0;
        ne.s0     = 8'h00;
        if (tbl) begin
            ne.has_s0 = 1'b1;
            ne.s0     = t_s0;
            ne.zero   = t_zero;
            ne.lerr   = t_lerr;
            if (t_zero) ne.syn = '0;
        end
        exp_q.push_back(ne);
    endtask

    always @(negedge clk) begin
        if (rst_n && syn_val && syn_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got syndrome %h, expected no result at %0t", syndrome, $time);
            end else begin
                e = exp_t'(exp_q.pop_front());
                n_out++;
                check("syndrome", syndrome, e.syn);
                check("syn_zero", SW'(syn_zero), SW'(e.zero));
                check("len_err", SW'(len_err), SW'(e.lerr));
                if (e.has_s0) check("s0", SW'(syndrome[7:0]), SW'(e.s0));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sym(input logic [7:0] d, input logic sop, input logic eop);
        logic ok;
        int   cyc;
        din     = d;
        din_sop = sop;
        din_eop = eop;
        din_val = 1'b1;
        cyc     = 0;
        do begin
            @(negedge clk);
            ok = din_rdy;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 200);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL din_accept_timeout: got din_rdy 0 for %0d cycles, expected accept", cyc);
        end
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frm_len; i++) begin
            send_sym(frm[i], i == 0, i == frm_len - 1);
            if (gaps && i < frm_len - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        @(negedge clk);
        check("latency_syn_val", SW'(syn_val), SW'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    typedef struct {
        string      name;
        int         len;
        int         pos;
        logic [7:0] val;
        logic [7:0] s0;
        logic       zero;
        logic       lerr;
    } vec_t;

    vec_t          tbl [8];
    logic [SW-1:0] exp1;
    int            kind;

    initial begin
        tbl[0] = '{"deg0_one",  16, 15, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[1] = '{"deg15_one", 16,  0, 8'h01, 8'h26, 1'b0, 1'b0};
        tbl[2] = '{"deg1_one",  16, 14, 8'h01, 8'h02, 1'b0, 1'b0};
        tbl[3] = '{"deg2_one",  16, 13, 8'h01, 8'h04, 1'b0, 1'b0};
        tbl[4] = '{"all_zero",  16,  0, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{"short10",   10,  9, 8'h01, 8'h01, 1'b0, 1'b1};
        tbl[6] = '{"single",     1,  0, 8'h55, 8'h55, 1'b0, 1'b1};
        tbl[7] = '{"long17",    17, 16, 8'h03, 8'h03, 1'b0, 1'b1};

        // reset values
        #2;
        check("rst_syn_val", SW'(syn_val), SW'(0));
        check("rst_syndrome", syndrome, '0);
        check("rst_syn_zero", SW'(syn_zero), SW'(0));
        check("rst_len_err", SW'(len_err), SW'(0));
        check("rst_din_rdy", SW'(din_rdy), SW'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // valid codeword, message 01..08
        for (int i = 0; i < K; i++) frm[i] = 8'(i + 1);
        build_codeword();
        push_exp(1'b1, 8'h00, 1'b1, 1'b0);
        send_frame(1'b0);

        // impulse / length table
        foreach (tbl[t]) begin
            frm_len = tbl[t].len;
            for (int i = 0; i < frm_len; i++) frm[i] = 8'h00;
            frm[tbl[t].pos] = tbl[t].val;
            push_exp(1'b1, tbl[t].s0, tbl[t].zero, tbl[t].lerr);
            send_frame(1'b0);
        end

        // sop after 5 symbols aborts the in-flight frame
        for (int i = 0; i < 5; i++) send_sym(8'($urandom), i == 0, 1'b0);
        for (int i = 0; i < K; i++) frm[i] = 8'($urandom);
        build_codeword();
        push_exp(1'b1, 8'h00, 1'b1, 1'b0);
        send_frame(1'b0);
        idle(2);

        // output held with syn_rdy low across two frames
        syn_rdy = 1'b0;
        fill_random(N);
        exp1 = model_syn();
        push_exp(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(1'b0);
        fill_random(N);
        push_exp(1'b0, 8'h00, 1'b0, 1'b0);
        din     = frm[0];
        din_sop = 1'b1;
        din_eop = 1'b0;
        din_val = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_din_rdy", SW'(din_rdy), SW'(0));
            check("hold_syn_val", SW'(syn_val), SW'(1));
            check("hold_syndrome", syndrome, exp1);
        end
        @(posedge clk);
        #1;
        syn_rdy = 1'b1;
        send_frame(1'b0);
        idle(2);

        // asynchronous reset in the middle of a frame
        fill_random(10);
        push_exp(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(1'b0);
        idle(2);
        for (int i = 0; i < 6; i++) send_sym(8'($urandom), i == 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_syn_val", SW'(syn_val), SW'(0));
        check("arst_syndrome", syndrome, '0);
        check("arst_syn_zero", SW'(syn_zero), SW'(0));
        check("arst_len_err", SW'(len_err), SW'(0));
        check("arst_din_rdy", SW'(din_rdy), SW'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send_sym(8'($urandom), 1'b0, i == 3);
        idle(3);
        @(negedge clk);
        check("idle_ignore_syn_val", SW'(syn_val), SW'(0));
        @(posedge clk);
        #1;
        fill_random(N);
        push_exp(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(1'b0);

        // randomized frames with random output backpressure and input gaps
        rand_rdy_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                for (int i = 0; i < K; i++) frm[i] = 8'($urandom);
                build_codeword();
            end else if (kind < 7) begin
                fill_random(N);
            end else begin
                fill_random($urandom_range(1, 20));
            end
            push_exp(1'b0, 8'h00, 1'b0, 1'b0);
            send_frame(1'b1);
            if ($urandom_range(0, 4) == 0) send_sym(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        end
        rand_rdy_en = 1'b0;
        @(posedge clk);
        #2;
        syn_rdy = 1'b1;
        idle(1);

        // count saturation: 272 symbols must not alias back to N
        fill_random(272);
        push_exp(1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(1'b0);

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        check("exp_q_empty", SW'(exp_q.size()), SW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
